// File: rtl/riscv_dec_alu_rf.sv
// -----------------------------------------------------------------------------
// riscv_dec_alu_rf
//   RV32I datapath slice for the multi-cycle core: instruction decoder, ALU and
//   a 2**REG_ADDR_W x XLEN register file. The decoder and the ALU are purely
//   combinational. The register file has two combinational read ports and one
//   clocked write port. This block holds no control state; the core FSM drives
//   the ALU operands and the register-file addresses.
//
//   Optional feature macro: REGFILE_BYPASS_EN
//     defined   - a read of rd_addr (rd_addr != 0) while reg_write_enable is
//                 high returns rd_data combinationally (write-to-read forwarding)
//     undefined - no forwarding; a written value is visible after the write edge
//
// Ports
//   clk                      clock; register file writes on posedge
//   rst                      asynchronous active-low reset; clears all registers
//   instr                    instruction word to decode
//   dec_opcode/rd/rs1/rs2    instruction fields
//   dec_imm                  formed immediate (0 for R-type and illegal opcodes)
//   dec_itype                R=0 I=1 S=2 SB=3 U=4 UJ=5 ILLEGAL=7
//   dec_alu_func             ALU operation implied by the instruction
//   dec_branch               funct3 (branch compare type)
//   alu_a, alu_b, alu_func   ALU operands and operation
//   branch                   compare type for br_result
//   alu_result, br_result    ALU result and branch condition
//   rs1/rs2_addr, rs1/rs2_data   read ports
//   reg_write_enable, rd_addr, rd_data   write port
// -----------------------------------------------------------------------------
module riscv_dec_alu_rf #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           instr,
    output logic [6:0]            dec_opcode,
    output logic [4:0]            dec_rd,
    output logic [4:0]            dec_rs1,
    output logic [4:0]            dec_rs2,
    output logic [XLEN-1:0]       dec_imm,
    output logic [2:0]            dec_itype,
    output logic [3:0]            dec_alu_func,
    output logic [2:0]            dec_branch,
    input  logic [XLEN-1:0]       alu_a,
    input  logic [XLEN-1:0]       alu_b,
    input  logic [3:0]            alu_func,
    input  logic [2:0]            branch,
    output logic [XLEN-1:0]       alu_result,
    output logic                  br_result,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic [XLEN-1:0]       rs1_data,
    output logic [XLEN-1:0]       rs2_data,
    input  logic                  reg_write_enable,
    input  logic [REG_ADDR_W-1:0] rd_addr,
    input  logic [XLEN-1:0]       rd_data
);

    localparam int NREGS = 2 ** REG_ADDR_W;

    // Opcodes
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IARITH = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // Instruction types
    localparam logic [2:0] IT_R   = 3'd0;
    localparam logic [2:0] IT_I   = 3'd1;
    localparam logic [2:0] IT_S   = 3'd2;
    localparam logic [2:0] IT_SB  = 3'd3;
    localparam logic [2:0] IT_U   = 3'd4;
    localparam logic [2:0] IT_UJ  = 3'd5;
    localparam logic [2:0] IT_ILL = 3'd7;

    // ALU operations
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    // ------------------------------------------------------------------ decode
    logic [2:0] funct3;

    assign dec_opcode = instr[6:0];
    assign dec_rd     = instr[11:7];
    assign dec_rs1    = instr[19:15];
    assign dec_rs2    = instr[24:20];
    assign funct3     = instr[14:12];
    assign dec_branch = funct3;

    // Maps funct3 (plus instr[30] where it selects SUB/SRA) to an ALU op.
    // allow_sub distinguishes R-type (ADD/SUB) from I-type (ADDI has no SUB).
    function automatic logic [3:0] arith_func(input logic [2:0] f3,
                                               input logic       bit30,
                                               input logic       allow_sub);
        logic [3:0] f;
        f = ALU_ADD;
        case (f3)
            3'd0: f = (allow_sub && bit30) ? ALU_SUB : ALU_ADD;
            3'd1: f = ALU_SLL;
            3'd2: f = ALU_SLT;
            3'd3: f = ALU_SLTU;
            3'd4: f = ALU_XOR;
            3'd5: f = bit30 ? ALU_SRA : ALU_SRL;
            3'd6: f = ALU_OR;
            3'd7: f = ALU_AND;
            default: f = ALU_ADD;
        endcase
        return f;
    endfunction

    always_comb begin
        dec_itype    = IT_ILL;
        dec_imm      = '0;
        dec_alu_func = ALU_ADD;
        case (dec_opcode)
            OP_R: begin
                dec_itype    = IT_R;
                dec_alu_func = arith_func(funct3, instr[30], 1'b1);
            end
            OP_IARITH: begin
                dec_itype    = IT_I;
                dec_imm      = {{(XLEN-12){instr[31]}}, instr[31:20]};
                dec_alu_func = arith_func(funct3, instr[30], 1'b0);
            end
            OP_LOAD, OP_JALR: begin
                dec_itype = IT_I;
                dec_imm   = {{(XLEN-12){instr[31]}}, instr[31:20]};
            end
            OP_STORE: begin
                dec_itype = IT_S;
                dec_imm   = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
            end
            OP_BRANCH: begin
                dec_itype = IT_SB;
                dec_imm   = {{(XLEN-13){instr[31]}}, instr[31], instr[7],
                             instr[30:25], instr[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                dec_itype = IT_U;
                dec_imm   = {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0};
            end
            OP_JAL: begin
                dec_itype = IT_UJ;
                dec_imm   = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12],
                             instr[20], instr[30:21], 1'b0};
            end
            default: ;
        endcase
    end

    // --------------------------------------------------------------------- ALU
    logic [4:0] shamt;
    assign shamt = alu_b[4:0];

    always_comb begin
        alu_result = '0;
        case (alu_func)
            ALU_ADD:  alu_result = alu_a + alu_b;
            ALU_SUB:  alu_result = alu_a - alu_b;
            ALU_SLL:  alu_result = alu_a << shamt;
            ALU_SLT:  alu_result = {{(XLEN-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
            ALU_SLTU: alu_result = {{(XLEN-1){1'b0}}, (alu_a < alu_b)};
            ALU_XOR:  alu_result = alu_a ^ alu_b;
            ALU_SRL:  alu_result = alu_a >> shamt;
            ALU_SRA:  alu_result = $unsigned($signed(alu_a) >>> shamt);
            ALU_OR:   alu_result = alu_a | alu_b;
            ALU_AND:  alu_result = alu_a & alu_b;
            default:  alu_result = '0;
        endcase
    end

    always_comb begin
        br_result = 1'b0;
        case (branch)
            3'd0: br_result = (alu_a == alu_b);
            3'd1: br_result = (alu_a != alu_b);
            3'd4: br_result = ($signed(alu_a) <  $signed(alu_b));
            3'd5: br_result = ($signed(alu_a) >= $signed(alu_b));
            3'd6: br_result = (alu_a <  alu_b);
            3'd7: br_result = (alu_a >= alu_b);
            default: br_result = 1'b0;
        endcase
    end

    // ----------------------------------------------------------- register file
    // One flop bank per register so the asynchronous clear reaches every entry
    // at once; x0 is a hard-wired zero and has no storage.
    logic [XLEN-1:0] rf_view [NREGS];

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign rf_view[gi] = '0;
            end else begin : g_store
                logic [XLEN-1:0] reg_q;
                logic [XLEN-1:0] reg_d;

                always_comb begin
                    reg_d = reg_q;
                    if (reg_write_enable && (rd_addr == REG_ADDR_W'(gi)))
                        reg_d = rd_data;
                end

                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) reg_q <= '0;
                    else      reg_q <= reg_d;
                end

                assign rf_view[gi] = reg_q;
            end
        end
    endgenerate

`ifdef REGFILE_BYPASS_EN
    // Forward the in-flight write to a same-cycle reader (never for x0).
    logic byp_rs1;
    logic byp_rs2;
    assign byp_rs1  = reg_write_enable && (rd_addr != '0) && (rd_addr == rs1_addr);
    assign byp_rs2  = reg_write_enable && (rd_addr != '0) && (rd_addr == rs2_addr);
    assign rs1_data = byp_rs1 ? rd_data : rf_view[rs1_addr];
    assign rs2_data = byp_rs2 ? rd_data : rf_view[rs2_addr];
`else
    assign rs1_data = rf_view[rs1_addr];
    assign rs2_data = rf_view[rs2_addr];
`endif

endmodule

// File: tb/tb_riscv_dec_alu_rf.sv
// -----------------------------------------------------------------------------
// tb_riscv_dec_alu_rf
//   Directed-vector bench for riscv_dec_alu_rf: decoder fields/immediates,
//   ALU and branch compare corner cases, register file write/read, x0,
//   asynchronous reset and same-cycle write/read behaviour.
// -----------------------------------------------------------------------------
module tb_riscv_dec_alu_rf;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic [6:0]  dec_opcode;
    logic [4:0]  dec_rd;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [31:0] dec_imm;
    logic [2:0]  dec_itype;
    logic [3:0]  dec_alu_func;
    logic [2:0]  dec_branch;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_func;
    logic [2:0]  branch;
    logic [31:0] alu_result;
    logic        br_result;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        reg_write_enable;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;

    int n_checks = 0;
    int n_errors = 0;

    riscv_dec_alu_rf dut (
        .clk              (clk),
        .rst              (rst),
        .instr            (instr),
        .dec_opcode       (dec_opcode),
        .dec_rd           (dec_rd),
        .dec_rs1          (dec_rs1),
        .dec_rs2          (dec_rs2),
        .dec_imm          (dec_imm),
        .dec_itype        (dec_itype),
        .dec_alu_func     (dec_alu_func),
        .dec_branch       (dec_branch),
        .alu_a            (alu_a),
        .alu_b            (alu_b),
        .alu_func         (alu_func),
        .branch           (branch),
        .alu_result       (alu_result),
        .br_result        (br_result),
        .rs1_addr         (rs1_addr),
        .rs2_addr         (rs2_addr),
        .rs1_data         (rs1_data),
        .rs2_data         (rs2_data),
        .reg_write_enable (reg_write_enable),
        .rd_addr          (rd_addr),
        .rd_data          (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    // Decode vector: instruction and hand-computed fields.
    task automatic dec_vec(input string tag, input logic [31:0] ins,
                           input logic [31:0] imm, input logic [2:0] ityp,
                           input logic [3:0] func);
        instr = ins;
        #1;
        check_eq({tag, ".imm"},   dec_imm, imm);
        check_eq({tag, ".itype"}, {29'd0, dec_itype}, {29'd0, ityp});
        check_eq({tag, ".func"},  {28'd0, dec_alu_func}, {28'd0, func});
    endtask

    task automatic alu_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] f, input logic [31:0] exp);
        alu_a = a; alu_b = b; alu_func = f;
        #1;
        check_eq(tag, alu_result, exp);
    endtask

    task automatic br_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] br, input logic exp);
        alu_a = a; alu_b = b; branch = br;
        #1;
        check_eq(tag, {31'd0, br_result}, {31'd0, exp});
    endtask

    // Write one register, then release the write strobe after the edge.
    task automatic rf_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        reg_write_enable = 1'b1; rd_addr = a; rd_data = d;
        @(posedge clk); #1;
        reg_write_enable = 1'b0;
    endtask

    initial begin
        rst = 1'b0; instr = '0; alu_a = '0; alu_b = '0; alu_func = '0; branch = '0;
        rs1_addr = '0; rs2_addr = '0; reg_write_enable = 1'b0; rd_addr = '0; rd_data = '0;

        // Writes attempted during reset must be ignored.
        @(negedge clk);
        reg_write_enable = 1'b1; rd_addr = 5'd9; rd_data = 32'hCAFE_F00D;
        @(posedge clk); #1;
        reg_write_enable = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        rs1_addr = 5'd9; rs2_addr = 5'd31; #1;
        check_eq("rst.x9_blocked", rs1_data, 32'h0);
        check_eq("rst.x31",        rs2_data, 32'h0);

        // Decoder
        instr = 32'hFFF00093; #1;
        check_eq("addi.opcode", {25'd0, dec_opcode}, 32'h13);
        check_eq("addi.rd",     {27'd0, dec_rd},  32'd1);
        check_eq("addi.rs1",    {27'd0, dec_rs1}, 32'd0);
        dec_vec("addi", 32'hFFF00093, 32'hFFFF_FFFF, 3'd1, 4'd0);

        instr = 32'h40208033; #1;
        check_eq("sub.rs1", {27'd0, dec_rs1}, 32'd1);
        check_eq("sub.rs2", {27'd0, dec_rs2}, 32'd2);
        dec_vec("sub", 32'h40208033, 32'h0, 3'd0, 4'd1);

        instr = 32'hFE209EE3; #1;
        check_eq("bne.branch", {29'd0, dec_branch}, 32'd1);
        dec_vec("bne",  32'hFE209EE3, 32'hFFFF_FFFC, 3'd3, 4'd0);
        dec_vec("sw",   32'h0020A423, 32'h0000_0008, 3'd2, 4'd0);
        dec_vec("srai", 32'h4030D093, 32'h0000_0403, 3'd1, 4'd7);
        dec_vec("lui",  32'h123452B7, 32'h1234_5000, 3'd4, 4'd0);
        dec_vec("jal",  32'h0080006F, 32'h0000_0008, 3'd5, 4'd0);
        dec_vec("ill",  32'hFFFFFFFF, 32'h0,         3'd7, 4'd0);

        // ALU
        alu_vec("alu.sra",   32'h8000_0000, 32'd4, 4'd7, 32'hF800_0000);
        alu_vec("alu.srl",   32'h8000_0000, 32'd4, 4'd6, 32'h0800_0000);
        alu_vec("alu.slt",   32'hFFFF_FFFF, 32'd1, 4'd3, 32'd1);
        alu_vec("alu.sltu",  32'hFFFF_FFFF, 32'd1, 4'd4, 32'd0);
        alu_vec("alu.add",   32'hFFFF_FFFF, 32'd1, 4'd0, 32'd0);
        alu_vec("alu.sub",   32'd0,         32'd1, 4'd1, 32'hFFFF_FFFF);
        alu_vec("alu.sll",   32'h1,         32'h23, 4'd2, 32'h8);
        alu_vec("alu.xor",   32'hF0F0_F0F0, 32'hFF00_FF00, 4'd5, 32'h0FF0_0FF0);
        alu_vec("alu.or",    32'hF0F0_F0F0, 32'h0F00_0000, 4'd8, 32'hFFF0_F0F0);
        alu_vec("alu.and",   32'hF0F0_F0F0, 32'hFF00_FF00, 4'd9, 32'hF000_F000);
        alu_vec("alu.undef", 32'h1234_5678, 32'h1, 4'd12, 32'h0);

        // Branch compare
        br_vec("br.bne_eq",  32'd3,         32'd3, 3'd1, 1'b0);
        br_vec("br.beq_eq",  32'd3,         32'd3, 3'd0, 1'b1);
        br_vec("br.blt",     32'hFFFF_FFFF, 32'd1, 3'd4, 1'b1);
        br_vec("br.bltu",    32'hFFFF_FFFF, 32'd1, 3'd6, 1'b0);
        br_vec("br.bge",     32'hFFFF_FFFF, 32'd1, 3'd5, 1'b0);
        br_vec("br.bgeu",    32'hFFFF_FFFF, 32'd1, 3'd7, 1'b1);
        br_vec("br.code2",   32'd3,         32'd3, 3'd2, 1'b0);

        // Register file
        rf_write(5'd5, 32'h0000_1234);
        rs1_addr = 5'd5; #1;
        check_eq("rf.x5", rs1_data, 32'h0000_1234);
        rf_write(5'd0, 32'h0000_DEAD);
        rs1_addr = 5'd0; rs2_addr = 5'd0; #1;
        check_eq("rf.x0_rs1", rs1_data, 32'h0);
        check_eq("rf.x0_rs2", rs2_data, 32'h0);

        // Same-cycle write/read of x7
        rf_write(5'd7, 32'h0000_1111);
        @(negedge clk);
        rs1_addr = 5'd7; rs2_addr = 5'd5;
        reg_write_enable = 1'b1; rd_addr = 5'd7; rd_data = 32'h0000_2222;
        #1;
`ifdef REGFILE_BYPASS_EN
        check_eq("rf.x7_same_cycle", rs1_data, 32'h0000_2222);
`else
        check_eq("rf.x7_same_cycle", rs1_data, 32'h0000_1111);
`endif
        check_eq("rf.x5_other_port", rs2_data, 32'h0000_1234);
        @(posedge clk); #1;
        reg_write_enable = 1'b0; #1;
        check_eq("rf.x7_after_edge", rs1_data, 32'h0000_2222);

        // Asynchronous reset mid-cycle
        @(negedge clk); #2;
        rs1_addr = 5'd5; #1;
        check_eq("rf.x5_pre_rst", rs1_data, 32'h0000_1234);
        rst = 1'b0; #1;
        check_eq("rf.x5_async_rst", rs1_data, 32'h0);
        rs1_addr = 5'd7; #1;
        check_eq("rf.x7_async_rst", rs1_data, 32'h0);
        rst = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
